// File: rtl/counter_ctrl_if.sv
// counter_ctrl_if
//   Command channel into the interval-counter sequencer. A command moves
//   on a rising edge where cmd_valid and cmd_ready are both high.
//
//   cmd_valid  master->slave  command present
//   cmd_ready  slave->master  sequencer can take a command this cycle
//   cmd_op     master->slave  0 CLEAR, 1 START, 2 STOP, 3 LOAD
//   cmd_data   master->slave  LOAD: interval, START: target (0 = free-run)
interface counter_ctrl_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_op;
    logic [31:0] cmd_data;

    modport master (
        output cmd_valid,
        output cmd_op,
        output cmd_data,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid,
        input  cmd_op,
        input  cmd_data,
        output cmd_ready
    );
endinterface

// File: rtl/counter_ctrl.sv
// counter_ctrl
//   Sequencer that owns the state/interval inputs of the 32-bit interval
//   counter. Takes CLEAR / START / STOP / LOAD commands one at a time and
//   auto-halts the counter when it reaches a programmed target, pulsing
//   done for one cycle. Every output comes straight from a flop.
//
//   Parameters
//     INTERVAL_MIN  smallest interval ever driven; also its reset value.
//                   Must be >= 2 so the counter cannot step past a target
//                   in the cycle the halt takes effect.
//   Ports
//     clk          rising-edge clock
//     rst          asynchronous, active-high reset
//     cmd          command channel (slave side)
//     counter_val  current counter output
//     state        to counter: 0 RESET, 1 RUN, 2 HALT
//     interval     to counter interval input
//     done         one-cycle pulse on target termination
//     busy         high exactly while state is RUN
module counter_ctrl #(
    parameter logic [31:0] INTERVAL_MIN = 32'd2
) (
    input  logic                 clk,
    input  logic                 rst,
    counter_ctrl_if.slave        cmd,
    input  logic [31:0]          counter_val,
    output logic [7:0]           state,
    output logic [31:0]          interval,
    output logic                 done,
    output logic                 busy
);

    typedef enum logic [1:0] {
        ST_RESET = 2'd0,
        ST_RUN   = 2'd1,
        ST_HALT  = 2'd2
    } fsm_t;

    localparam logic [1:0] OP_CLEAR = 2'd0;
    localparam logic [1:0] OP_START = 2'd1;
    localparam logic [1:0] OP_STOP  = 2'd2;
    localparam logic [1:0] OP_LOAD  = 2'd3;

    // Floor the requested interval at INTERVAL_MIN (unsigned compare).
    function automatic logic [31:0] clamp_interval(input logic [31:0] req);
        return (req < INTERVAL_MIN) ? INTERVAL_MIN : req;
    endfunction

    fsm_t        fsm_q,      fsm_d;
    logic [31:0] target_q,   target_d;
    logic [31:0] interval_q, interval_d;
    logic        ready_q,    ready_d;
    logic        done_q,     done_d;
    logic        busy_q,     busy_d;

    logic        accept;
    logic        match;
    logic        cmd_blocks_match;

    assign accept = cmd.cmd_valid && ready_q;

    // Target reached while running; a zero target means free-run.
    assign match = (fsm_q == ST_RUN) && (target_q != 32'd0) &&
                   (counter_val >= target_q);

    // Any accepted command other than LOAD overrides a same-cycle match.
    assign cmd_blocks_match = accept && (cmd.cmd_op != OP_LOAD);

    always_comb begin
        fsm_d      = fsm_q;
        target_d   = target_q;
        interval_d = interval_q;
        done_d     = 1'b0;

        if (match && !cmd_blocks_match) begin
            fsm_d  = ST_HALT;
            done_d = 1'b1;
        end

        if (accept) begin
            case (cmd.cmd_op)
                OP_CLEAR: begin
                    fsm_d    = ST_RESET;
                    target_d = 32'd0;
                end
                OP_START: begin
                    fsm_d    = ST_RUN;
                    target_d = cmd.cmd_data;
                end
                OP_STOP: begin
                    if (fsm_q == ST_RUN) begin
                        fsm_d = ST_HALT;
                    end
                end
                OP_LOAD: begin
                    interval_d = clamp_interval(cmd.cmd_data);
                end
            endcase
        end

        // One idle cycle after every accept, independent of op and state.
        ready_d = !accept;
        busy_d  = (fsm_d == ST_RUN);
    end

    // Registered stage: everything visible outside comes from here.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fsm_q      <= ST_RESET;
            target_q   <= 32'd0;
            interval_q <= INTERVAL_MIN;
            ready_q    <= 1'b1;
            done_q     <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            fsm_q      <= fsm_d;
            target_q   <= target_d;
            interval_q <= interval_d;
            ready_q    <= ready_d;
            done_q     <= done_d;
            busy_q     <= busy_d;
        end
    end

    assign state         = {6'd0, fsm_q};
    assign interval      = interval_q;
    assign done          = done_q;
    assign busy          = busy_q;
    assign cmd.cmd_ready = ready_q;

endmodule

// File: tb/tb_counter_ctrl.sv
// tb_counter_ctrl
//   Directed bench for counter_ctrl with a behavioural interval counter
//   attached to its state/interval outputs. Inputs change and outputs are
//   sampled on the falling edge.
module tb_counter_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] counter_val = 32'd0;
    logic [31:0] pre = 32'd0;
    logic [7:0]  state;
    logic [31:0] interval;
    logic        done;
    logic        busy;

    int vectors     = 0;
    int miscompares = 0;
    int done_cnt    = 0;

    counter_ctrl_if cif ();

    counter_ctrl #(.INTERVAL_MIN(32'd2)) dut (
        .clk         (clk),
        .rst         (rst),
        .cmd         (cif),
        .counter_val (counter_val),
        .state       (state),
        .interval    (interval),
        .done        (done),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    // Interval counter: RESET clears, RUN steps once every 'interval'
    // cycles, HALT holds.
    always @(posedge clk) begin
        if (state == 8'd0) begin
            counter_val <= 32'd0;
            pre         <= 32'd0;
        end else if (state == 8'd1) begin
            if (pre >= interval - 32'd1) begin
                pre         <= 32'd0;
                counter_val <= counter_val + 32'd1;
            end else begin
                pre <= pre + 32'd1;
            end
        end
    end

    always @(negedge clk) begin
        if (done === 1'b1) done_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [1:0] op, input logic [31:0] data);
        for (int i = 0; i < 4 && cif.cmd_ready !== 1'b1; i++) @(negedge clk);
        chk("send_ready", 32'(cif.cmd_ready), 32'd1);
        cif.cmd_valid = 1'b1;
        cif.cmd_op    = op;
        cif.cmd_data  = data;
        @(negedge clk);
        cif.cmd_valid = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1);
    end

    initial begin
        cif.cmd_valid = 1'b0;
        cif.cmd_op    = 2'd0;
        cif.cmd_data  = 32'd0;
        #1 rst = 1'b1;
        repeat (2) @(negedge clk);

        // Reset values
        chk("rst_state",    32'(state), 32'd0);
        chk("rst_interval", interval, 32'd2);
        chk("rst_done",     32'(done), 32'd0);
        chk("rst_busy",     32'(busy), 32'd0);
        chk("rst_ready",    32'(cif.cmd_ready), 32'd1);
        rst = 1'b0;
        @(negedge clk);

        // LOAD 5, START 3: run to target, halt exactly on 3
        send(2'd3, 32'd5);
        chk("load5_interval", interval, 32'd5);
        chk("load5_state",    32'(state), 32'd0);
        chk("load5_ready",    32'(cif.cmd_ready), 32'd0);
        @(negedge clk);
        chk("load5_ready_back", 32'(cif.cmd_ready), 32'd1);
        send(2'd1, 32'd3);
        chk("start3_state", 32'(state), 32'd1);
        chk("start3_busy",  32'(busy), 32'd1);
        for (int i = 0; i < 100 && done !== 1'b1; i++) @(negedge clk);
        chk("tgt_done",    32'(done), 32'd1);
        chk("tgt_count",   counter_val, 32'd3);
        chk("tgt_state",   32'(state), 32'd2);
        chk("tgt_busy",    32'(busy), 32'd0);
        @(negedge clk);
        chk("tgt_done_clr", 32'(done), 32'd0);
        repeat (12) @(negedge clk);
        chk("tgt_hold",    counter_val, 32'd3);
        chk("tgt_pulses",  32'(done_cnt), 32'd1);

        // LOAD clamping
        send(2'd3, 32'd0);
        chk("load0", interval, 32'd2);
        send(2'd3, 32'd1);
        chk("load1", interval, 32'd2);
        send(2'd3, 32'hFFFF_FFFF);
        chk("load_max", interval, 32'hFFFF_FFFF);
        send(2'd3, 32'd3);
        chk("load3", interval, 32'd3);
        send(2'd3, 32'd2);
        chk("load2", interval, 32'd2);
        chk("load_keeps_state", 32'(state), 32'd2);

        // Free-run, STOP at 10, resume without clearing
        send(2'd0, 32'd0);
        chk("clr_state", 32'(state), 32'd0);
        repeat (2) @(negedge clk);
        chk("clr_count", counter_val, 32'd0);
        send(2'd1, 32'd0);
        chk("fr_state1", 32'(state), 32'd1);
        for (int i = 0; i < 100 && counter_val != 32'd10; i++) @(negedge clk);
        chk("fr_reach10", counter_val, 32'd10);
        send(2'd2, 32'd0);
        chk("fr_state2", 32'(state), 32'd2);
        chk("fr_busy2",  32'(busy), 32'd0);
        repeat (4) @(negedge clk);
        chk("fr_hold10", counter_val, 32'd10);
        send(2'd1, 32'd0);
        chk("fr_state3", 32'(state), 32'd1);
        for (int i = 0; i < 20 && counter_val == 32'd10; i++) @(negedge clk);
        chk("fr_resume", counter_val, 32'd11);
        repeat (30) @(negedge clk);
        chk("fr_no_halt", 32'(state), 32'd1);
        chk("fr_no_done", 32'(done_cnt), 32'd1);

        // STOP in the same cycle as the target match
        send(2'd0, 32'd0);
        send(2'd1, 32'd4);
        for (int i = 0; i < 100 && counter_val != 32'd4; i++) @(negedge clk);
        chk("stopm_reach4", counter_val, 32'd4);
        send(2'd2, 32'd0);
        chk("stopm_state", 32'(state), 32'd2);
        chk("stopm_done",  32'(done), 32'd0);
        @(negedge clk);
        chk("stopm_done2", 32'(done_cnt), 32'd1);
        chk("stopm_count", counter_val, 32'd4);

        // Back-to-back CLEAR then START with valid held high
        cif.cmd_valid = 1'b1;
        cif.cmd_op    = 2'd0;
        cif.cmd_data  = 32'd0;
        chk("b2b_ready0", 32'(cif.cmd_ready), 32'd1);
        @(negedge clk);
        chk("b2b_ready1", 32'(cif.cmd_ready), 32'd0);
        chk("b2b_state1", 32'(state), 32'd0);
        cif.cmd_op = 2'd1;
        @(negedge clk);
        chk("b2b_ready2", 32'(cif.cmd_ready), 32'd1);
        chk("b2b_state2", 32'(state), 32'd0);
        @(negedge clk);
        chk("b2b_state3", 32'(state), 32'd1);
        cif.cmd_valid = 1'b0;

        // LOAD in the match cycle: halt, done and new interval all happen
        send(2'd0, 32'd0);
        send(2'd1, 32'd2);
        for (int i = 0; i < 100 && counter_val != 32'd2; i++) @(negedge clk);
        chk("ldm_reach2", counter_val, 32'd2);
        send(2'd3, 32'd7);
        chk("ldm_state",    32'(state), 32'd2);
        chk("ldm_done",     32'(done), 32'd1);
        chk("ldm_interval", interval, 32'd7);
        @(negedge clk);
        chk("ldm_done_clr", 32'(done), 32'd0);
        chk("ldm_pulses",   32'(done_cnt), 32'd2);
        chk("ldm_count",    counter_val, 32'd2);

        // START with target already met: one RUN cycle, then halt + done
        send(2'd1, 32'd1);
        chk("met_state1", 32'(state), 32'd1);
        chk("met_done1",  32'(done), 32'd0);
        @(negedge clk);
        chk("met_state2", 32'(state), 32'd2);
        chk("met_done2",  32'(done), 32'd1);
        chk("met_busy2",  32'(busy), 32'd0);
        chk("met_count",  32'(counter_val <= 32'd3), 32'd1);

        // Asynchronous reset mid-run with a command pending
        send(2'd3, 32'd6);
        send(2'd1, 32'd0);
        repeat (5) @(negedge clk);
        chk("arst_pre_state", 32'(state), 32'd1);
        cif.cmd_valid = 1'b1;
        cif.cmd_op    = 2'd3;
        cif.cmd_data  = 32'd9;
        #1 rst = 1'b1;
        #1;
        chk("arst_state",    32'(state), 32'd0);
        chk("arst_interval", interval, 32'd2);
        chk("arst_busy",     32'(busy), 32'd0);
        chk("arst_done",     32'(done), 32'd0);
        chk("arst_ready",    32'(cif.cmd_ready), 32'd1);
        @(negedge clk);
        cif.cmd_valid = 1'b0;
        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("arst_post_interval", interval, 32'd2);
        chk("arst_post_state",    32'(state), 32'd0);
        chk("arst_post_count",    counter_val, 32'd0);
        chk("arst_post_pulses",   32'(done_cnt), 32'd3);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/counter_ctrl.md
# counter_ctrl

Command-driven sequencer for the 32-bit interval counter. It owns the counter's `state` and `interval` inputs and accepts one command at a time over a valid/ready handshake: clear, start, stop, or load interval. It watches the counter output and auto-halts at a programmed target, pulsing `done` when that happens. It sits between the control front end (switches or bus register) and the counter instance.

## Interface
- `INTERVAL_MIN`, default 2: smallest interval the block will drive. Also the reset value of `interval`. Must be ≥ 2 so a target stop is exact.
- `clk`  in  1  sole clock; all logic on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `cmd_valid`  in  1  command present.
- `cmd_ready`  out  1  block can accept a command this cycle.
- `cmd_op`  in  2  0 = CLEAR, 1 = START, 2 = STOP, 3 = LOAD.
- `cmd_data`  in  32  LOAD: new interval. START: target count (0 = free-run). Ignored for the other ops.
- `counter_val`  in  32  the counter's `counter` output.
- `state`  out  8  to the counter: 8'd0 RESET, 8'd1 RUN, 8'd2 HALT. No other values are ever driven.
- `interval`  out  32  to the counter's `interval` input.
- `done`  out  1  one-cycle pulse on target termination.
- `busy`  out  1  high exactly when `state` == RUN.

## Operation
- Accept = `cmd_valid` && `cmd_ready`, sampled at a rising edge. Unaccepted commands have no effect.
- FSM states are RESET, RUN and HALT; `state` is the registered FSM encoding.
- CLEAR, from any state:
  - goes to RESET and stays there, holding the counter at 0;
  - sets `target` to 0.
- START, from RESET or HALT: goes to RUN and captures `target` = `cmd_data`.
- START while in RUN: stays in RUN and re-captures `target`.
- STOP: RUN → HALT. In RESET or HALT it is accepted with no effect.
- LOAD, legal in any state:
  - `interval` = max(`cmd_data`, `INTERVAL_MIN`), as an unsigned compare;
  - FSM state is unchanged.
- Target match:
  - condition: in RUN, `target` != 0, and `counter_val` >= `target` (unsigned);
  - action: next edge goes to HALT and `done` = 1 for one cycle.
- Free-run (`target` = 0): never auto-halts. Counter wrap-around from 32'hFFFFFFFF to 0 is not an event.
- Priority when a match and an accepted command fall in the same cycle:
  - the command wins and `done` stays 0;
  - exception: an accepted LOAD does not block the match. The halt and `done` still occur, and the LOAD is also applied.
- START when `counter_val` is already >= `cmd_data`:
  - enters RUN for one cycle, then halts with `done`;
  - the counter may advance at most once in that cycle.

## Timing
- Reset values (asynchronous):
  - `state` = 8'd0, `interval` = `INTERVAL_MIN`, `target` = 0;
  - `done` = 0, `busy` = 0, `cmd_ready` = 1.
- All outputs are registered. No combinational path from any input to any output.
- Command latency:
  - a command accepted at edge E updates `state` and `interval` after E;
  - the counter acts on them at E+1.
- Throughput:
  - `cmd_ready` drops to 0 for the one cycle after an accept, then returns to 1;
  - at most one command every 2 cycles;
  - `cmd_ready` does not depend on `cmd_op` or on the FSM state.
- Target latency:
  - a match visible in the cycle after counter edge Ec gives `state` = HALT and `done` = 1 after Ec+1;
  - `done` clears after Ec+2.
  - Because `interval` ≥ 2, the counter cannot increment at Ec+1, so its final value equals `target` exactly.
- `rst` asserted mid-run forces RESET immediately, without waiting for a clock edge. A command pending in that cycle is dropped.

## Test plan
- Reset release, then LOAD 5, then START 3, with the counter model attached:
  - `interval` = 5;
  - `state` = 1 the cycle after the START accept;
  - the counter reaches 3, then `state` = 2 and `done` pulses once;
  - `counter_val` holds at 3.
- LOAD 0 and LOAD 1 → `interval` = 2 each time. LOAD 32'hFFFFFFFF → `interval` = 32'hFFFFFFFF.
- START 0 (free-run), STOP after 10 counts, then START 0 again:
  - `state` sequence is 1, 2, 1;
  - the counter resumes from 10 without clearing;
  - `done` is never asserted.
- In RUN with target 4, issue STOP in the exact cycle `counter_val` becomes 4 → `state` = 2, `done` stays 0.
- Back-to-back: `cmd_valid` held high with CLEAR then START:
  - `cmd_ready` pattern is 1, 0, 1;
  - the START is accepted exactly 2 cycles after the CLEAR;
  - `state` goes 0 then 1.
- Assert `rst` mid-run with `cmd_valid` high → all outputs take their reset values at once; no command takes effect after release.
